// File: rtl/xbar_rr.sv
// PORTS x PORTS router crossbar: a round-robin arbiter per output with wormhole
// locking and downstream backpressure, followed by a registered output stage.
module xbar_rr #(
  parameter int PORTS      = 5,
  parameter int DATA_WIDTH = 32,
  parameter int VCH_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PORTS*DATA_WIDTH-1:0]   idata,
  input  logic [PORTS-1:0]              ivalid,
  input  logic [PORTS*VCH_WIDTH-1:0]    ivch,
  input  logic [PORTS-1:0]              itail,
  input  logic [PORTS-1:0]              req,
  input  logic [PORTS*PORTS-1:0]        port,
  input  logic [PORTS-1:0]              oready,
  output logic [PORTS*PORTS-1:0]        grt,
  output logic [PORTS*DATA_WIDTH-1:0]   odata,
  output logic [PORTS-1:0]              ovalid,
  output logic [PORTS*VCH_WIDTH-1:0]    ovch
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [PW-1:0] LAST = PW'(PORTS - 1);

  // Per-output arbiter state; state/owner/ptr are the points to bind checkers to.
  logic [PORTS-1:0]                 state;
  logic [PORTS-1:0][PW-1:0]         owner;
  logic [PORTS-1:0][PW-1:0]         ptr;

  logic [PORTS-1:0][PORTS-1:0]      r;
  logic [PORTS-1:0]                 hit;
  logic [PORTS-1:0][PW-1:0]         sel;
  logic [PORTS-1:0]                 xfer;
  logic [PORTS-1:0]                 sel_tail;
  logic [PORTS-1:0][DATA_WIDTH-1:0] sel_data;
  logic [PORTS-1:0][VCH_WIDTH-1:0]  sel_vch;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] cur);
    return (cur == LAST) ? '0 : cur + PW'(1);
  endfunction

  // r[o][i]: input i wants output o this cycle.
  always_comb begin
    r = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        r[o][i] = req[i] & port[i*PORTS + o];
      end
    end
  end

  // Rotating scan from ptr; iterating downward leaves the first hit in rotation order.
  always_comb begin
    int            sum;
    logic [PW-1:0] cand;
    sum  = 0;
    cand = '0;
    hit  = '0;
    sel  = '0;
    for (int o = 0; o < PORTS; o++) begin
      if (!reset && oready[o]) begin
        if (state[o] == LOCKED) begin
          hit[o] = r[o][owner[o]];
          sel[o] = owner[o];
        end else begin
          for (int k = PORTS - 1; k >= 0; k--) begin
            sum = int'(ptr[o]) + k;
            if (sum >= PORTS) sum = sum - PORTS;
            cand = PW'(sum);
            if (r[o][cand]) begin
              hit[o] = 1'b1;
              sel[o] = cand;
            end
          end
        end
      end
    end
  end

  always_comb begin
    grt      = '0;
    xfer     = '0;
    sel_tail = '0;
    sel_data = '0;
    sel_vch  = '0;
    for (int o = 0; o < PORTS; o++) begin
      sel_data[o] = idata[int'(sel[o])*DATA_WIDTH +: DATA_WIDTH];
      sel_vch[o]  = ivch[int'(sel[o])*VCH_WIDTH +: VCH_WIDTH];
      sel_tail[o] = itail[sel[o]];
      xfer[o]     = hit[o] & ivalid[sel[o]];
      for (int i = 0; i < PORTS; i++) begin
        grt[i*PORTS + o] = hit[o] && (sel[o] == PW'(i));
      end
    end
  end

  // A granted cycle without ivalid is a bubble: nothing moves and the lock holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= '0;
      owner  <= '0;
      ptr    <= '0;
      ovalid <= '0;
      odata  <= '0;
      ovch   <= '0;
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        ovalid[o] <= xfer[o];
        if (xfer[o]) begin
          odata[o*DATA_WIDTH +: DATA_WIDTH] <= sel_data[o];
          ovch[o*VCH_WIDTH +: VCH_WIDTH]    <= sel_vch[o];
          if (state[o] == IDLE) begin
            if (sel_tail[o]) begin
              ptr[o] <= next_ptr(sel[o]);
            end else begin
              state[o] <= LOCKED;
              owner[o] <= sel[o];
            end
          end else if (sel_tail[o]) begin
            state[o] <= IDLE;
            ptr[o]   <= next_ptr(owner[o]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_rr.sv
// Bench for xbar_rr: directed scenarios plus random traffic against a packet-level
// reference model, and a rotation check on an 8-port, 64-bit instance.
module tb_xbar_rr;

  localparam int P   = 5;
  localparam int DW  = 32;
  localparam int VW  = 2;
  localparam int P8  = 8;
  localparam int DW8 = 64;

  logic clk;
  logic reset;

  logic [P*DW-1:0] idata;
  logic [P-1:0]    ivalid;
  logic [P*VW-1:0] ivch;
  logic [P-1:0]    itail;
  logic [P-1:0]    req;
  logic [P*P-1:0]  port;
  logic [P-1:0]    oready;
  logic [P*P-1:0]  grt;
  logic [P*DW-1:0] odata;
  logic [P-1:0]    ovalid;
  logic [P*VW-1:0] ovch;

  logic [P8*DW8-1:0] idata8;
  logic [P8-1:0]     ivalid8;
  logic [P8*VW-1:0]  ivch8;
  logic [P8-1:0]     itail8;
  logic [P8-1:0]     req8;
  logic [P8*P8-1:0]  port8;
  logic [P8-1:0]     oready8;
  logic [P8*P8-1:0]  grt8;
  logic [P8*DW8-1:0] odata8;
  logic [P8-1:0]     ovalid8;
  logic [P8*VW-1:0]  ovch8;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];

  // Reference model: per-output lock flag, owner and rotation start.
  bit          m_locked[P];
  int          m_owner[P];
  int          m_ptr[P];
  logic [P-1:0]    m_ovalid;
  logic [P*DW-1:0] m_odata;
  logic [P*VW-1:0] m_ovch;

  xbar_rr #(.PORTS(P), .DATA_WIDTH(DW), .VCH_WIDTH(VW)) dut (
    .clk(clk), .reset(reset), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .itail(itail), .req(req), .port(port), .oready(oready), .grt(grt),
    .odata(odata), .ovalid(ovalid), .ovch(ovch)
  );

  xbar_rr #(.PORTS(P8), .DATA_WIDTH(DW8), .VCH_WIDTH(VW)) dut8 (
    .clk(clk), .reset(reset), .idata(idata8), .ivalid(ivalid8), .ivch(ivch8),
    .itail(itail8), .req(req8), .port(port8), .oready(oready8), .grt(grt8),
    .odata(odata8), .ovalid(ovalid8), .ovch(ovch8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P*P-1:0] model_grant();
    logic [P*P-1:0] g;
    int cand[$];
    int i;
    g = '0;
    if (reset) return g;
    for (int o = 0; o < P; o++) begin
      cand.delete();
      for (int k = 0; k < P; k++) begin
        i = (m_ptr[o] + k) % P;
        if (req[i] && port[i*P + o]) cand.push_back(i);
      end
      if (!oready[o]) continue;
      if (m_locked[o]) begin
        if (req[m_owner[o]] && port[m_owner[o]*P + o]) g[m_owner[o]*P + o] = 1'b1;
      end else if (cand.size() > 0) begin
        g[cand[0]*P + o] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic void model_update(input logic [P*P-1:0] g);
    int gi;
    if (reset) begin
      for (int o = 0; o < P; o++) begin
        m_locked[o] = 1'b0;
        m_owner[o]  = 0;
        m_ptr[o]    = 0;
      end
      m_ovalid = '0;
      m_odata  = '0;
      m_ovch   = '0;
      return;
    end
    for (int o = 0; o < P; o++) begin
      gi = -1;
      for (int i = 0; i < P; i++) if (g[i*P + o]) gi = i;
      m_ovalid[o] = (gi >= 0) && ivalid[gi];
      if (m_ovalid[o]) begin
        m_odata[o*DW +: DW] = idata[gi*DW +: DW];
        m_ovch[o*VW +: VW]  = ivch[gi*VW +: VW];
        if (!m_locked[o]) begin
          if (itail[gi]) m_ptr[o] = (gi + 1) % P;
          else begin
            m_locked[o] = 1'b1;
            m_owner[o]  = gi;
          end
        end else if (itail[gi]) begin
          m_locked[o] = 1'b0;
          m_ptr[o]    = (gi + 1) % P;
        end
      end
    end
  endfunction

  task automatic clear_in();
    req    = '0;
    port   = '0;
    ivalid = '0;
    itail  = '0;
    oready = '1;
  endtask

  task automatic drive(input int i, input int o, input logic v, input logic t);
    req[i]            = 1'b1;
    port[i*P +: P]    = P'(1) << o;
    ivalid[i]         = v;
    itail[i]          = t;
    idata[i*DW +: DW] = $urandom;
    ivch[i*VW +: VW]  = VW'($urandom);
  endtask

  // Inputs are stable here; compare the combinational grant and advance the model.
  task automatic eval();
    logic [P*P-1:0] g;
    #1;
    g = model_grant();
    check("grt", grt, g);
    model_update(g);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("ovalid", ovalid, m_ovalid);
    check("odata", odata, m_odata);
    check("ovch", ovch, m_ovch);
  endtask

  initial begin
    logic [P*P-1:0]  perm;
    logic [P*DW-1:0] snap;
    logic [DW8-1:0]  d8[P8];
    int idx;

    idata = '0; ivch = '0;
    idata8 = '0; ivch8 = '0; ivalid8 = '0; itail8 = '0; req8 = '0; port8 = '0; oready8 = '1;
    clear_in();

    // Reset held 2 cycles with every input requesting output 0.
    reset = 1'b1;
    for (int i = 0; i < P; i++) drive(i, 0, 1'b1, 1'b1);
    eval(); tick();
    eval(); tick();
    check("rst_ovalid8", ovalid8, 8'h00);
    reset = 1'b0;
    eval();
    check("rst_first_grant", grt[0], 1'b1);
    tick();

    // Round-robin of single-flit packets from inputs 0, 2, 4 into output 1.
    clear_in();
    exp_q = '{0, 2, 4, 0, 2, 4};
    for (int n = 0; n < 6; n++) begin
      drive(0, 1, 1'b1, 1'b1);
      drive(2, 1, 1'b1, 1'b1);
      drive(4, 1, 1'b1, 1'b1);
      eval();
      idx = int'(exp_q.pop_front());
      check("rr_order", grt[idx*P + 1], 1'b1);
      tick();
      check("rr_ovalid1", ovalid[1], 1'b1);
    end

    // Wormhole lock: input 3 owns output 2 for 4 flits, input 1 waits.
    clear_in();
    drive(3, 2, 1'b1, 1'b0);
    eval();
    check("lock_head", grt[3*P + 2], 1'b1);
    tick();
    for (int n = 1; n < 4; n++) begin
      drive(3, 2, 1'b1, n == 3);
      drive(1, 2, 1'b1, 1'b1);
      eval();
      check("lock_block", grt[1*P + 2], 1'b0);
      tick();
    end
    clear_in();
    drive(1, 2, 1'b1, 1'b1);
    eval();
    check("lock_release", grt[1*P + 2], 1'b1);
    tick();

    // Backpressure and a bubble inside a 3-flit packet from input 0 on output 2.
    clear_in();
    drive(0, 2, 1'b1, 1'b0);
    eval();
    check("bp_head", grt[0*P + 2], 1'b1);
    tick();
    for (int n = 0; n < 2; n++) begin
      drive(0, 2, 1'b1, 1'b0);
      drive(4, 2, 1'b1, 1'b1);
      oready[2] = 1'b0;
      eval();
      check("bp_nogrant", grt[0*P + 2] | grt[4*P + 2], 1'b0);
      tick();
      check("bp_ovalid", ovalid[2], 1'b0);
    end
    oready = '1;
    drive(0, 2, 1'b1, 1'b0);
    drive(4, 2, 1'b1, 1'b1);
    eval();
    check("bp_resume", grt[0*P + 2], 1'b1);
    tick();
    drive(0, 2, 1'b0, 1'b0);
    drive(4, 2, 1'b1, 1'b1);
    eval();
    check("bubble_block", grt[4*P + 2], 1'b0);
    tick();
    check("bubble_ovalid", ovalid[2], 1'b0);
    drive(0, 2, 1'b1, 1'b1);
    drive(4, 2, 1'b1, 1'b1);
    eval(); tick();
    clear_in();
    drive(4, 2, 1'b1, 1'b1);
    eval();
    check("bp_release", grt[4*P + 2], 1'b1);
    tick();

    // Parallel permutation: input i -> output (i+1) mod P.
    clear_in();
    perm = '0;
    for (int i = 0; i < P; i++) begin
      drive(i, (i + 1) % P, 1'b1, 1'b1);
      perm[i*P + (i + 1) % P] = 1'b1;
    end
    snap = idata;
    eval();
    check("par_grt", grt, perm);
    tick();
    check("par_ovalid", ovalid, {P{1'b1}});
    for (int o = 0; o < P; o++)
      check("par_data", odata[o*DW +: DW], snap[((o + P - 1) % P)*DW +: DW]);

    // Reset after the 2nd flit of a 4-flit packet releases the lock.
    clear_in();
    for (int n = 0; n < 2; n++) begin
      drive(2, 3, 1'b1, 1'b0);
      eval(); tick();
    end
    reset = 1'b1;
    drive(2, 3, 1'b1, 1'b0);
    drive(0, 3, 1'b1, 1'b1);
    eval(); tick();
    reset = 1'b0;
    drive(2, 3, 1'b1, 1'b0);
    drive(0, 3, 1'b1, 1'b1);
    eval();
    check("rst_mid_grant", grt[0*P + 3], 1'b1);
    tick();

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      clear_in();
      for (int i = 0; i < P; i++) begin
        if ($urandom_range(0, 3) != 0)
          drive(i, $urandom_range(0, P - 1), $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
      end
      for (int o = 0; o < P; o++) oready[o] = ($urandom_range(0, 3) != 0);
      eval(); tick();
    end
    reset = 1'b0;
    clear_in();

    // 8-port, 64-bit instance: all inputs send single flits to output 3.
    for (int i = 0; i < P8; i++) begin
      d8[i] = {$urandom, $urandom};
      idata8[i*DW8 +: DW8] = d8[i];
      port8[i*P8 +: P8]    = 8'b0000_1000;
    end
    req8 = '1; ivalid8 = '1; itail8 = '1; oready8 = '1;
    exp_q.delete();
    for (int n = 0; n < 10; n++) exp_q.push_back(32'(n % P8));
    for (int n = 0; n < 10; n++) begin
      #1;
      idx = int'(exp_q.pop_front());
      check("rr8_grt", grt8, 64'(1) << (idx*P8 + 3));
      @(posedge clk);
      #1;
      check("rr8_ovalid", ovalid8, 8'b0000_1000);
      check("rr8_odata", odata8[3*DW8 +: DW8], d8[idx]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
